// File: rtl/branch_resolve_pkg.sv
// Shared constants and types for the ID-stage branch resolver.
package branch_pkg;

  localparam logic [31:0] NOP_INSTR_DFLT = 32'hD503201F;

  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [7:0] OP_CBZ   = 8'hB4;
  localparam logic [7:0] OP_BCOND = 8'h54;
  localparam logic [4:0] COND_LT  = 5'h0B;

  typedef enum logic [1:0] {RUN, WAIT_FLAGS, SQUASH} br_state_t;

  typedef enum logic [1:0] {TGT_NONE, TGT_B, TGT_CBZ} tgt_sel_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch <-> decode boundary signals; stats outputs exist only with BRANCH_STATS_EN.
interface branch_resolve_if;
  logic [31:0] if_instr;
  logic [63:0] if_target_b;
  logic [63:0] if_target_cbz;
  logic        id_rt_zero;
  logic        flag_n;
  logic        flag_v;
  logic        flags_pending;
  logic        br_taken;
  logic [63:0] br_target;
  logic        stall_if;
  logic [31:0] id_instr;
  logic        id_valid;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
`endif

  modport master (
    output if_instr, if_target_b, if_target_cbz, id_rt_zero, flag_n, flag_v, flags_pending,
    input  br_taken, br_target, stall_if, id_instr, id_valid
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_taken
`endif
  );

  modport slave (
    input  if_instr, if_target_b, if_target_cbz, id_rt_zero, flag_n, flag_v, flags_pending,
    output br_taken, br_target, stall_if, id_instr, id_valid
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_taken
`endif
  );
endinterface

// File: rtl/branch_resolve_cond_eval.sv
// Combinational decode of B / CBZ / B.LT in ID and their taken condition.
module br_cond_eval
  import branch_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic        rt_zero_i,
  input  logic        flag_n_i,
  input  logic        flag_v_i,
  input  logic        flags_pending_i,
  output logic        is_branch_o,
  output logic        taken_o,
  output tgt_sel_t    target_sel_o,
  output logic        needs_flags_o
);

  always_comb begin
    is_branch_o   = 1'b0;
    taken_o       = 1'b0;
    target_sel_o  = TGT_NONE;
    needs_flags_o = 1'b0;
    if (valid_i) begin
      if (instr_i[31:26] == OP_B) begin
        is_branch_o  = 1'b1;
        taken_o      = 1'b1;
        target_sel_o = TGT_B;
      end else if (instr_i[31:24] == OP_CBZ) begin
        is_branch_o  = 1'b1;
        taken_o      = rt_zero_i;
        target_sel_o = TGT_CBZ;
      end else if (instr_i[31:24] == OP_BCOND && instr_i[4:0] == COND_LT) begin
        // Committed flags are only trusted once no flag writer is in flight.
        is_branch_o   = 1'b1;
        needs_flags_o = 1'b1;
        taken_o       = (flag_n_i != flag_v_i) && !flags_pending_i;
        target_sel_o  = TGT_CBZ;
      end
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// IF/ID register, branch-resolve FSM and optional stats (BRANCH_STATS_EN).
module branch_resolve
  import branch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DFLT
) (
  input logic              clk,
  input logic              reset,
  branch_resolve_if.slave  bus
);

  br_state_t   state_q, state_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [63:0] tgt_b_q, tgt_b_d;
  logic [63:0] tgt_cbz_q, tgt_cbz_d;

  logic     is_branch, taken, needs_flags;
  tgt_sel_t target_sel;
  logic     br_taken, stall_if;

  br_cond_eval u_cond_eval (
    .instr_i         (id_instr_q),
    .valid_i         (id_valid_q),
    .rt_zero_i       (bus.id_rt_zero),
    .flag_n_i        (bus.flag_n),
    .flag_v_i        (bus.flag_v),
    .flags_pending_i (bus.flags_pending),
    .is_branch_o     (is_branch),
    .taken_o         (taken),
    .target_sel_o    (target_sel),
    .needs_flags_o   (needs_flags)
  );

  always_comb begin
    state_d    = state_q;
    id_instr_d = bus.if_instr;
    id_valid_d = 1'b1;
    tgt_b_d    = bus.if_target_b;
    tgt_cbz_d  = bus.if_target_cbz;
    br_taken   = 1'b0;
    stall_if   = 1'b0;
    unique case (state_q)
      RUN, WAIT_FLAGS: begin
        if (needs_flags && bus.flags_pending) begin
          stall_if   = 1'b1;
          id_instr_d = id_instr_q;
          id_valid_d = id_valid_q;
          tgt_b_d    = tgt_b_q;
          tgt_cbz_d  = tgt_cbz_q;
          state_d    = WAIT_FLAGS;
        end else if (taken) begin
          // Wrong-path fetch is dropped; one bubble enters ID.
          br_taken   = 1'b1;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          tgt_b_d    = '0;
          tgt_cbz_d  = '0;
          state_d    = SQUASH;
        end else begin
          state_d = RUN;
        end
      end
      SQUASH:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      tgt_b_q    <= '0;
      tgt_cbz_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      tgt_b_q    <= tgt_b_d;
      tgt_cbz_q  <= tgt_cbz_d;
    end
  end

  always_comb begin
    unique case (target_sel)
      TGT_B:   bus.br_target = tgt_b_q;
      TGT_CBZ: bus.br_target = tgt_cbz_q;
      default: bus.br_target = '0;
    endcase
  end

  assign bus.br_taken = br_taken;
  assign bus.stall_if = stall_if;
  assign bus.id_instr = id_instr_q;
  assign bus.id_valid = id_valid_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_taken_q;
  logic        resolved;

  // A stalled B.LT is counted only on the edge it finally resolves.
  assign resolved = is_branch && !stall_if;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      if (resolved) stat_branches_q <= stat_branches_q + 32'd1;
      if (br_taken) stat_taken_q    <= stat_taken_q + 32'd1;
    end
  end

  assign bus.stat_branches = stat_branches_q;
  assign bus.stat_taken    = stat_taken_q;
`endif

endmodule
